// File: rtl/bus_arbiter.sv
// bus_arbiter: grants the shared serial bus to one master, revoking it on missing ack or overlong hold.
// Define ARB_ROUND_ROBIN_EN for round-robin priority; otherwise fixed priority (lowest index wins).
module bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ID_WIDTH    = 2,
  parameter int ACK_WAIT    = 4,
  parameter int TIMEOUT_LEN = 6
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] b_request,
  input  logic                   b_bus_utilizing,
  output logic [NUM_MASTERS-1:0] b_grant,
  output logic [ID_WIDTH-1:0]    grant_id,
  output logic                   arb_busy,
  output logic                   arb_timeout
);
  localparam int CW = (TIMEOUT_LEN > $clog2(ACK_WAIT)) ? TIMEOUT_LEN : $clog2(ACK_WAIT);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_WAIT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'((1 << TIMEOUT_LEN) - 1);
  typedef enum logic [1:0] {IDLE, GRANT, BUSY, RELEASE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] id_q, id_d, last_q, last_d, win_id;
  logic busy_q, to_q, to_d, win_found;
  int idx;
  assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  always_comb begin
    win_id = '0;
    win_found = 1'b0;
    idx = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      idx = (int'(last_q) + 1 + i) % NUM_MASTERS;
`else
      idx = i;
`endif
      if (!win_found && b_request[idx]) begin
        win_found = 1'b1;
        win_id = ID_WIDTH'(idx);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    grant_d = grant_q;
    id_d = id_q;
    last_d = last_q;
    to_d = 1'b0;
    case (state_q)
      IDLE: if (win_found) begin
        state_d = GRANT;
        cnt_d = '0;
        grant_d = NUM_MASTERS'(1) << win_id;
        id_d = win_id;
      end
      GRANT: begin
        cnt_d = cnt_inc;
        if (b_bus_utilizing) begin
          state_d = BUSY;
          cnt_d = '0;
        end else if (!b_request[id_q] || cnt_q == ACK_LAST) begin
          state_d = RELEASE;
          to_d = b_request[id_q];
        end
      end
      BUSY: begin
        cnt_d = cnt_inc;
        if (!b_bus_utilizing || cnt_q == HOLD_LAST) begin
          state_d = RELEASE;
          to_d = b_bus_utilizing;
        end
      end
      RELEASE: state_d = IDLE;
    endcase
    // outputs drop on entry to RELEASE so the bus is free for a full turnaround cycle
    if (state_d == RELEASE) begin
      grant_d = '0;
      id_d = '0;
      last_d = id_q;
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      grant_q <= '0;
      id_q <= '0;
      last_q <= ID_WIDTH'(NUM_MASTERS - 1);
      busy_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      grant_q <= grant_d;
      id_q <= id_d;
      last_q <= last_d;
      busy_q <= state_d != IDLE;
      to_q <= to_d;
    end
  assign b_grant = grant_q;
  assign grant_id = id_q;
  assign arb_busy = busy_q;
  assign arb_timeout = to_q;
endmodule
